// File: rtl/dmem_arbiter_if.sv
// One requester's view of the data-memory arbiter: request fields in,
// grant/completion pulses and load data back.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between the
// CPU load/store unit (m0) and the debug/loader port (m1), with sub-word lanes.
//
// state | meaning
// IDLE  | arbitrate, latch winner, pulse gnt
// ISSUE | drive memory strobe, byte enables and lane data
// CAPT  | load read in flight in the memory
// DONE  | capture/extend load data, pulse done
// ERR   | illegal or misaligned access, pulse done+err, no memory access
module dmem_arbiter #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      m0,
  dmem_arbiter_if.slave      m1,
  output logic               mem_en,
  output logic               mem_we,
  output logic [3:0]         mem_be,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]  state;
  logic        last;
  logic        sel;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        win;
  logic        w_we;
  logic        w_uns;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_addr;

  assign m0.gnt   = gnt_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m0.done  = done_q[0];
  assign m1.done  = done_q[1];
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

  // Address bits above the memory's word index are deliberately dropped.
  assign unused_addr = ^addr_q[31:DEPTH_W+2];

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_legal = 1'b1;
      2'b01:   is_legal = ~lo[0];
      2'b10:   is_legal = (lo == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // On a tie the port that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    if (m0.req && m1.req) win = ~last;
    else if (m1.req)      win = 1'b1;
    w_we    = win ? m1.we    : m0.we;
    w_uns   = win ? m1.uns   : m0.uns;
    w_size  = win ? m1.size  : m0.size;
    w_addr  = win ? m1.addr  : m0.addr;
    w_wdata = win ? m1.wdata : m0.wdata;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Every output is a pulse register cleared each cycle unless its state sets it,
  // so outputs lag the state by one cycle; the load capture in DONE therefore
  // lines up with the memory's registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        S_IDLE: begin
          if (m0.req || m1.req) begin
            sel     <= win;
            last    <= win;
            we_q    <= w_we;
            uns_q   <= w_uns;
            size_q  <= w_size;
            addr_q  <= w_addr;
            wdata_q <= w_wdata;
            gnt_q   <= win ? 2'b10 : 2'b01;
            state   <= is_legal(w_size, w_addr[1:0]) ? S_ISSUE : S_ERR;
          end
        end
        S_ISSUE: begin
          mem_en    <= 1'b1;
          mem_we    <= we_q;
          mem_be    <= we_q ? st_be : 4'b1111;
          mem_wdata <= we_q ? st_wdata : 32'd0;
          mem_addr  <= addr_q[DEPTH_W+1:2];
          state     <= we_q ? S_DONE : S_CAPT;
        end
        S_CAPT: begin
          state <= S_DONE;
        end
        S_DONE: begin
          done_q <= sel ? 2'b10 : 2'b01;
          if (sel) rdata1_q <= we_q ? 32'd0 : ld_data;
          else     rdata0_q <= we_q ? 32'd0 : ld_data;
          state  <= S_IDLE;
        end
        S_ERR: begin
          done_q <= sel ? 2'b10 : 2'b01;
          err_q  <= sel ? 2'b10 : 2'b01;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
